// File: rtl/sram_oq_pkg.sv
// Shared definitions for the output-queue SRAM write controller:
// sideband bit offsets inside a data word, the per-queue state type and
// the queue depth helper.
package sram_oq_pkg;

  // Per-queue packet state.
  typedef enum logic [1:0] {
    Q_IDLE     = 2'd0,
    Q_WRITING  = 2'd1,
    Q_DROPPING = 2'd2
  } q_state_e;

  // End-of-packet sideband bit, just above the data bytes.
  function automatic int unsigned sb_eop_bit(input int unsigned tdata_width);
    return 8 * tdata_width;
  endfunction

  // Start-of-packet sideband bit; carried through but not interpreted.
  function automatic int unsigned sb_sop_bit(input int unsigned tdata_width);
    return 8 * tdata_width + 1;
  endfunction

  // Words per queue region.
  function automatic int unsigned queue_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/sram_oq_queue_ctx.sv
// Context of one output queue: packet FSM, speculative write pointer,
// committed pointer and free-word count.
// Ports:
//   memclk, reset      clock, synchronous active-high reset
//   word_valid         word for this queue arrives this cycle
//   word_eop           that word ends its packet
//   rel_valid          read side frees rel_words words of this queue
//   rel_words          words freed (1..DEPTH)
//   wr_c               word is written this cycle (combinational)
//   drop_c             packet is dropped this cycle (combinational)
//   commit_c           packet is committed this cycle (combinational)
//   wr_ptr             current speculative write offset
//   commit_ptr         committed tail offset
module sram_oq_queue_ctx
  import sram_oq_pkg::*;
#(
  parameter int unsigned QUEUE_ADDR_WIDTH = 16
) (
  input  logic                        memclk,
  input  logic                        reset,
  input  logic                        word_valid,
  input  logic                        word_eop,
  input  logic                        rel_valid,
  input  logic [QUEUE_ADDR_WIDTH:0]   rel_words,
  output logic                        wr_c,
  output logic                        drop_c,
  output logic                        commit_c,
  output logic [QUEUE_ADDR_WIDTH-1:0] wr_ptr,
  output logic [QUEUE_ADDR_WIDTH-1:0] commit_ptr
);

  localparam int unsigned AW    = QUEUE_ADDR_WIDTH;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SW    = AW + 2;
  localparam int unsigned DEPTH = queue_depth(AW);

  q_state_e        state, state_n;
  logic [AW-1:0]   wr_ptr_n, commit_ptr_n;
  logic [CW-1:0]   free, free_n;
  logic [CW-1:0]   restore;
  logic [CW-1:0]   spec_words;
  logic [AW-1:0]   spec_diff;
  logic [SW-1:0]   free_sum;
  logic            has_room;

  assign has_room  = (free != '0);
  assign spec_diff = wr_ptr - commit_ptr;
  // In WRITING at least one word is outstanding, so equal pointers mean a
  // full region of speculative words rather than none.
  assign spec_words = (spec_diff == '0) ? CW'(DEPTH) : CW'(spec_diff);

  // State and pointer registers.
  always_ff @(posedge memclk) begin
    if (reset) begin
      state      <= Q_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      free       <= CW'(DEPTH);
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      free       <= free_n;
    end
  end

  // Next-state, pointer and free-count logic.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    wr_c         = 1'b0;
    drop_c       = 1'b0;
    commit_c     = 1'b0;
    restore      = '0;
    free_n       = free;
    free_sum     = '0;

    case (state)
      Q_IDLE: begin
        if (word_valid) begin
          if (has_room) begin
            wr_c     = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
            if (word_eop) begin
              commit_c     = 1'b1;
              commit_ptr_n = wr_ptr + AW'(1);
            end else begin
              state_n = Q_WRITING;
            end
          end else begin
            drop_c  = 1'b1;
            state_n = word_eop ? Q_IDLE : Q_DROPPING;
          end
        end
      end
      Q_WRITING: begin
        if (word_valid) begin
          if (has_room) begin
            wr_c     = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
            if (word_eop) begin
              commit_c     = 1'b1;
              commit_ptr_n = wr_ptr + AW'(1);
              state_n      = Q_IDLE;
            end
          end else begin
            // Abort: rewind to the last commit and give back the words.
            wr_ptr_n = commit_ptr;
            restore  = spec_words;
            drop_c   = 1'b1;
            state_n  = word_eop ? Q_IDLE : Q_DROPPING;
          end
        end
      end
      Q_DROPPING: begin
        if (word_valid && word_eop) begin
          state_n = Q_IDLE;
        end
      end
      default: begin
        state_n = Q_IDLE;
      end
    endcase

    // Write, abort and release combine; result saturates at DEPTH.
    free_sum = SW'(free) + SW'(restore)
             + (rel_valid ? SW'(rel_words) : SW'(0))
             - (wr_c ? SW'(1) : SW'(0));
    if (free_sum > SW'(DEPTH)) begin
      free_n = CW'(DEPTH);
    end else begin
      free_n = free_sum[CW-1:0];
    end
  end

endmodule

// File: rtl/sram_oq_write_ctrl.sv
// Output-queue SRAM write controller. Takes the arbiter's word stream,
// writes each word into its queue's circular SRAM region, drops packets
// that do not fit and publishes committed tails to the read side.
// Ports:
//   memclk, reset      clock, synchronous active-high reset
//   din_valid          word valid
//   queue_id           destination queue of the word
//   din                word: data bytes, EOP/SOP sideband, opaque bits
//   rel_valid          read side frees words
//   rel_qid            queue being freed
//   rel_words          words freed (1..DEPTH)
//   sram_wr_en         SRAM write strobe
//   sram_wr_addr       SRAM address {qid, offset}
//   sram_wr_data       word written, unmodified
//   commit_valid       pulse: packet committed
//   commit_qid         queue of committed packet
//   commit_tail        committed tails, queue q at slice q
//   drop_valid         pulse: packet dropped
//   drop_qid           queue of dropped packet
//   err_bad_qid        sticky: out-of-range queue_id seen
module sram_oq_write_ctrl
  import sram_oq_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH      = 24,
  parameter int unsigned NUM_QUEUES       = 5,
  parameter int unsigned QUEUE_ID_WIDTH   = 3,
  parameter int unsigned QUEUE_ADDR_WIDTH = 16,
  parameter int unsigned SRAM_ADDR_WIDTH  = QUEUE_ID_WIDTH + QUEUE_ADDR_WIDTH
) (
  input  logic                                   memclk,
  input  logic                                   reset,
  input  logic                                   din_valid,
  input  logic [QUEUE_ID_WIDTH-1:0]              queue_id,
  input  logic [8*TDATA_WIDTH+9:0]               din,
  input  logic                                   rel_valid,
  input  logic [QUEUE_ID_WIDTH-1:0]              rel_qid,
  input  logic [QUEUE_ADDR_WIDTH:0]              rel_words,
  output logic                                   sram_wr_en,
  output logic [SRAM_ADDR_WIDTH-1:0]             sram_wr_addr,
  output logic [8*TDATA_WIDTH+9:0]               sram_wr_data,
  output logic                                   commit_valid,
  output logic [QUEUE_ID_WIDTH-1:0]              commit_qid,
  output logic [NUM_QUEUES*QUEUE_ADDR_WIDTH-1:0] commit_tail,
  output logic                                   drop_valid,
  output logic [QUEUE_ID_WIDTH-1:0]              drop_qid,
  output logic                                   err_bad_qid
);

  localparam int unsigned AW      = QUEUE_ADDR_WIDTH;
  localparam int unsigned EOP_BIT = sb_eop_bit(TDATA_WIDTH);

  logic [NUM_QUEUES-1:0]    acc, rel_hit;
  logic [NUM_QUEUES-1:0]    wr_v, drop_v, commit_v;
  logic [AW-1:0]            wr_ptr_q [NUM_QUEUES];
  logic [NUM_QUEUES*AW-1:0] commit_ptr_flat;

  logic                      wr_sel, drop_sel, commit_sel, bad_qid_c;
  logic [AW-1:0]             wr_ptr_sel;
  logic                      commit_pend;
  logic [QUEUE_ID_WIDTH-1:0] commit_pend_qid;

  assign bad_qid_c = din_valid && (32'(queue_id) >= NUM_QUEUES);

  // One context per queue; decode routes words and releases.
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
    logic [AW-1:0] commit_ptr_g;

    assign acc[g]     = din_valid && (queue_id == QUEUE_ID_WIDTH'(g));
    assign rel_hit[g] = rel_valid && (rel_qid == QUEUE_ID_WIDTH'(g));

    sram_oq_queue_ctx #(
      .QUEUE_ADDR_WIDTH (AW)
    ) u_ctx (
      .memclk     (memclk),
      .reset      (reset),
      .word_valid (acc[g]),
      .word_eop   (din[EOP_BIT]),
      .rel_valid  (rel_hit[g]),
      .rel_words  (rel_words),
      .wr_c       (wr_v[g]),
      .drop_c     (drop_v[g]),
      .commit_c   (commit_v[g]),
      .wr_ptr     (wr_ptr_q[g]),
      .commit_ptr (commit_ptr_g)
    );

    assign commit_ptr_flat[g*AW +: AW] = commit_ptr_g;
  end

  // At most one queue is addressed per cycle, so OR-combine its results.
  always_comb begin
    wr_sel     = 1'b0;
    drop_sel   = 1'b0;
    commit_sel = 1'b0;
    wr_ptr_sel = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      wr_sel     = wr_sel | wr_v[q];
      drop_sel   = drop_sel | drop_v[q];
      commit_sel = commit_sel | commit_v[q];
      if (acc[q]) begin
        wr_ptr_sel = wr_ptr_q[q];
      end
    end
  end

  // Output registers; commit is staged once more so it follows its write.
  always_ff @(posedge memclk) begin
    if (reset) begin
      sram_wr_en      <= 1'b0;
      sram_wr_addr    <= '0;
      sram_wr_data    <= '0;
      commit_pend     <= 1'b0;
      commit_pend_qid <= '0;
      commit_valid    <= 1'b0;
      commit_qid      <= '0;
      commit_tail     <= '0;
      drop_valid      <= 1'b0;
      drop_qid        <= '0;
      err_bad_qid     <= 1'b0;
    end else begin
      sram_wr_en   <= wr_sel;
      commit_pend  <= commit_sel;
      commit_valid <= commit_pend;
      commit_tail  <= commit_ptr_flat;
      drop_valid   <= drop_sel;
      if (wr_sel) begin
        sram_wr_addr <= SRAM_ADDR_WIDTH'({queue_id, wr_ptr_sel});
        sram_wr_data <= din;
      end
      if (commit_sel) begin
        commit_pend_qid <= queue_id;
      end
      if (commit_pend) begin
        commit_qid <= commit_pend_qid;
      end
      if (drop_sel) begin
        drop_qid <= queue_id;
      end
      if (bad_qid_c) begin
        err_bad_qid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_oq_write_ctrl.sv
// Scoreboard bench for sram_oq_write_ctrl with a packet-level reference
// model: directed scenarios followed by randomized traffic.
module tb_sram_oq_write_ctrl;

  localparam int TDW   = 4;
  localparam int NQ    = 5;
  localparam int QIDW  = 3;
  localparam int QAW   = 4;
  localparam int DEPTH = 16;
  localparam int W     = 8*TDW + 10;
  localparam int SAW   = QIDW + QAW;
  localparam int EOPB  = 8*TDW;
  localparam int NEVER = 32'h7fff_ffff;

  logic               memclk;
  logic               reset;
  logic               din_valid;
  logic [QIDW-1:0]    queue_id;
  logic [W-1:0]       din;
  logic               rel_valid;
  logic [QIDW-1:0]    rel_qid;
  logic [QAW:0]       rel_words;
  logic               sram_wr_en;
  logic [SAW-1:0]     sram_wr_addr;
  logic [W-1:0]       sram_wr_data;
  logic               commit_valid;
  logic [QIDW-1:0]    commit_qid;
  logic [NQ*QAW-1:0]  commit_tail;
  logic               drop_valid;
  logic [QIDW-1:0]    drop_qid;
  logic               err_bad_qid;

  sram_oq_write_ctrl #(
    .TDATA_WIDTH      (TDW),
    .NUM_QUEUES       (NQ),
    .QUEUE_ID_WIDTH   (QIDW),
    .QUEUE_ADDR_WIDTH (QAW)
  ) dut (
    .memclk       (memclk),
    .reset        (reset),
    .din_valid    (din_valid),
    .queue_id     (queue_id),
    .din          (din),
    .rel_valid    (rel_valid),
    .rel_qid      (rel_qid),
    .rel_words    (rel_words),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .commit_valid (commit_valid),
    .commit_qid   (commit_qid),
    .commit_tail  (commit_tail),
    .drop_valid   (drop_valid),
    .drop_qid     (drop_qid),
    .err_bad_qid  (err_bad_qid)
  );

  initial memclk = 1'b0;
  always #5 memclk = ~memclk;

  int cyc = 0;
  always @(posedge memclk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [SAW-1:0] addr; logic [W-1:0] data; } wr_exp_t;
  typedef struct { int cyc; int qid; logic [NQ*QAW-1:0] tail; } cm_exp_t;
  typedef struct { int cyc; int qid; } dr_exp_t;

  wr_exp_t wq[$];
  cm_exp_t cq[$];
  dr_exp_t dq[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model: occupancy bookkeeping per queue.
  int m_free   [NQ];
  int m_commit [NQ];
  int m_spec   [NQ];   // words of the open packet already written
  bit m_drop   [NQ];   // discarding the rest of a packet
  int err_from;

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) begin
      m_free[q]   = DEPTH;
      m_commit[q] = 0;
      m_spec[q]   = 0;
      m_drop[q]   = 1'b0;
    end
    err_from = NEVER;
    wq.delete();
    cq.delete();
    dq.delete();
  endtask

  function automatic logic [NQ*QAW-1:0] model_tails();
    logic [NQ*QAW-1:0] t;
    t = '0;
    for (int q = 0; q < NQ; q++) t[q*QAW +: QAW] = QAW'(m_commit[q]);
    return t;
  endfunction

  // Drive one cycle of stimulus and predict its outcome.
  task automatic step(input bit v, input int q, input bit eop,
                      input bit rv, input int rq, input int rw);
    logic [W-1:0] d;
    @(negedge memclk);
    d = W'({$urandom(), $urandom()});
    d[EOPB] = eop;
    din_valid = v;
    queue_id  = QIDW'(q);
    din       = d;
    rel_valid = rv;
    rel_qid   = QIDW'(rq);
    rel_words = (QAW+1)'(rw);
    if (v && q < NQ) begin
      if (m_drop[q]) begin
        if (eop) m_drop[q] = 1'b0;
      end else if (m_free[q] > 0) begin
        wq.push_back('{cyc + 1, SAW'(q*DEPTH + (m_commit[q] + m_spec[q]) % DEPTH), d});
        m_spec[q]++;
        m_free[q]--;
        if (eop) begin
          m_commit[q] = (m_commit[q] + m_spec[q]) % DEPTH;
          m_spec[q]   = 0;
          cq.push_back('{cyc + 2, q, model_tails()});
        end
      end else begin
        dq.push_back('{cyc + 1, q});
        m_free[q] += m_spec[q];
        m_spec[q]  = 0;
        m_drop[q]  = !eop;
      end
    end else if (v && err_from > cyc + 1) begin
      err_from = cyc + 1;
    end
    if (rv && rq < NQ) begin
      m_free[rq] = m_free[rq] + rw;
      if (m_free[rq] > DEPTH) m_free[rq] = DEPTH;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 1);
  endtask

  task automatic packet(input int q, input int len);
    for (int i = 0; i < len; i++) step(1'b1, q, i == len - 1, 1'b0, 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({sram_wr_en, sram_wr_addr, commit_valid, commit_tail, drop_valid, err_bad_qid} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not zero after reset (wr_en=%0b addr=%0h cv=%0b tail=%0h dv=%0b err=%0b), required all 0",
               tag, sram_wr_en, sram_wr_addr, commit_valid, commit_tail, drop_valid, err_bad_qid);
    end
  endtask

  task automatic do_reset();
    idle(3);
    @(negedge memclk);
    reset     = 1'b1;
    din_valid = 1'b0;
    rel_valid = 1'b0;
    @(posedge memclk);
    model_reset();
    @(negedge memclk);
    check_zero_outputs("mid_reset");
    reset = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT presents an output.
  always @(negedge memclk) begin
    if (mon_en) begin
      if (sram_wr_en) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: write addr=%0h at cycle %0d, required no write", sram_wr_addr, cyc);
        end else begin
          wr_exp_t e;
          e = wq.pop_front();
          if (e.cyc != cyc || e.addr !== sram_wr_addr || e.data !== sram_wr_data) begin
            errors++;
            $display("FAIL wr: cycle %0d addr %0h data %0h, required cycle %0d addr %0h data %0h",
                     cyc, sram_wr_addr, sram_wr_data, e.cyc, e.addr, e.data);
          end
        end
      end
      if (commit_valid) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: qid=%0d at cycle %0d, required no commit", commit_qid, cyc);
        end else begin
          cm_exp_t e;
          e = cq.pop_front();
          if (e.cyc != cyc || 32'(commit_qid) != e.qid || commit_tail !== e.tail) begin
            errors++;
            $display("FAIL commit: cycle %0d qid %0d tail %0h, required cycle %0d qid %0d tail %0h",
                     cyc, commit_qid, commit_tail, e.cyc, e.qid, e.tail);
          end
        end
      end
      if (drop_valid) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL drop_unexpected: qid=%0d at cycle %0d, required no drop", drop_qid, cyc);
        end else begin
          dr_exp_t e;
          e = dq.pop_front();
          if (e.cyc != cyc || 32'(drop_qid) != e.qid) begin
            errors++;
            $display("FAIL drop: cycle %0d qid %0d, required cycle %0d qid %0d", cyc, drop_qid, e.cyc, e.qid);
          end
        end
      end
      // Expectations whose due cycle has passed were never produced.
      if (wq.size() != 0 && wq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL wr_missing: addr %0h due cycle %0d, not seen by %0d", wq[0].addr, wq[0].cyc, cyc);
        void'(wq.pop_front());
      end
      if (cq.size() != 0 && cq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL commit_missing: qid %0d due cycle %0d, not seen by %0d", cq[0].qid, cq[0].cyc, cyc);
        void'(cq.pop_front());
      end
      if (dq.size() != 0 && dq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL drop_missing: qid %0d due cycle %0d, not seen by %0d", dq[0].qid, dq[0].cyc, cyc);
        void'(dq.pop_front());
      end
      checks++;
      if (err_bad_qid !== (cyc >= err_from)) begin
        errors++;
        $display("FAIL err_bad_qid: %0b at cycle %0d, required %0b", err_bad_qid, cyc, cyc >= err_from);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    queue_id  = '0;
    din       = '0;
    rel_valid = 1'b0;
    rel_qid   = '0;
    rel_words = '0;
    model_reset();
    repeat (3) @(negedge memclk);
    check_zero_outputs("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // 3-word packet to q2: 0x20..0x22, tail2 = 3.
    packet(2, 3);
    idle(3);

    // Interleaved 2-word packets on q0 and q1.
    step(1'b1, 0, 1'b0, 1'b0, 0, 1);
    step(1'b1, 1, 1'b0, 1'b0, 0, 1);
    step(1'b1, 0, 1'b1, 1'b0, 0, 1);
    step(1'b1, 1, 1'b1, 1'b0, 0, 1);
    idle(3);

    // Oversized packet on q3 aborts, then a normal packet fits again.
    packet(3, 20);
    idle(2);
    packet(3, 4);
    idle(3);

    // q4 to 14/16, then release coinciding with a word; packet wraps.
    packet(4, 14);
    idle(2);
    step(1'b1, 4, 1'b0, 1'b1, 4, 8);
    step(1'b1, 4, 1'b0, 1'b0, 0, 1);
    step(1'b1, 4, 1'b0, 1'b0, 0, 1);
    step(1'b1, 4, 1'b1, 1'b0, 0, 1);
    idle(3);

    // Out-of-range queue id.
    step(1'b1, 6, 1'b1, 1'b0, 0, 1);
    idle(4);

    // Reset in the middle of a q1 packet, then a fresh packet.
    step(1'b1, 1, 1'b0, 1'b0, 0, 1);
    step(1'b1, 1, 1'b0, 1'b0, 0, 1);
    do_reset();
    packet(1, 3);
    idle(3);

    // Randomized traffic with releases and occasional bad ids.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 6) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7), $urandom_range(1, 16));
    end
    idle(5);

    checks++;
    if (wq.size() + cq.size() + dq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", wq.size() + cq.size() + dq.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
